// File: rtl/vga_pkg.sv
// Purpose: timing constants and colour expansion shared by the VGA scanout path.
// Latency: none (declarations only).
// Backpressure: none.
// Contents: default 640x480@60 timing, framebuffer geometry, counter width,
//           and the channel-to-DAC colour replication function.
package vga_pkg;

  // Default 640x480@60 timing, in pixel ticks (horizontal) and lines (vertical).
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;

  // Framebuffer geometry (160x120 stored, upsampled 4x4 on the way out).
  localparam int FB_WIDTH  = 160;
  localparam int FB_HEIGHT = 120;
  localparam int FB_ADDR_W = 15;

  // Wide enough for the 800-tick line and the 525-line frame.
  localparam int CNT_W = 11;

  // Replicate a w-bit channel value MSB-first across 8 DAC bits,
  // e.g. 1-bit 1 -> 8'hFF, 2-bit 2'b10 -> 8'b10101010.
  // ch holds the channel right-justified.
  function automatic logic [7:0] expand_channel(input logic [7:0] ch, input int w);
    logic [7:0] r;
    logic [2:0] dst;
    logic [2:0] src;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      dst    = 3'(7 - i);
      src    = 3'(w - 1 - (i % w));
      r[dst] = ch[src];
    end
    return r;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Purpose: pixel-tick phase, h/v raster counters, region decode, frame pulse.
// Latency: decode is combinational on the current (h,v); frame_start_o lags its tick by one clock.
// Backpressure: none; free-running from reset.
// Ports: clk_i/rst_ni clock and async active-low reset; phase_o half-rate pixel clock;
//        tick_o pixel tick; h_o/v_o raster position; active_o/hs_n_o/vs_n_o region decode;
//        frame_start_o one-clock pulse after the (last,last) -> (0,0) wrap.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FRONT  = DEF_V_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic             phase_o,
  output logic             tick_o,
  output logic [CNT_W-1:0] h_o,
  output logic [CNT_W-1:0] v_o,
  output logic             active_o,
  output logic             hs_n_o,
  output logic             vs_n_o,
  output logic             frame_start_o
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);

  logic             phase_q, phase_d;
  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;
  logic             fs_q, fs_d;
  logic             h_wrap, v_wrap;

  assign h_wrap = (h_q == H_LAST);
  assign v_wrap = (v_q == V_LAST);

  always_comb begin
    phase_d = ~phase_q;
    h_d     = h_q;
    v_d     = v_q;
    // Counters move only on the tick clock (phase high).
    if (phase_q) begin
      h_d = h_wrap ? '0 : h_q + CNT_W'(1);
      if (h_wrap) begin
        v_d = v_wrap ? '0 : v_q + CNT_W'(1);
      end
    end
    fs_d = phase_q && h_wrap && v_wrap;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q <= 1'b0;
      h_q     <= '0;
      v_q     <= '0;
      fs_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      h_q     <= h_d;
      v_q     <= v_d;
      fs_q    <= fs_d;
    end
  end

  assign phase_o       = phase_q;
  assign tick_o        = phase_q;
  assign h_o           = h_q;
  assign v_o           = v_q;
  assign active_o      = (h_q < H_ACT) && (v_q < V_ACT);
  assign hs_n_o        = !((h_q >= HS_BEG) && (h_q < HS_END));
  assign vs_n_o        = !((v_q >= VS_BEG) && (v_q < VS_END));
  assign frame_start_o = fs_q;

endmodule

// File: rtl/vga_scanout.sv
// Purpose: scan a 160x120 video RAM, upsample 4x4 and drive 640x480@60 VGA pins.
// Latency: 2 pixel ticks (4 clocks) from raster position to pins; RAM read has 1 clock.
// Backpressure: none; the RAM must answer one clock after rd_addr, with no wait states.
// Ports: clock/resetn; rd_addr/rd_data to the video RAM ({R,G,B}, R in MSBs);
//        VGA_R/G/B, VGA_HS/VS (active low), VGA_BLANK_N, VGA_SYNC_N, VGA_CLK to the DAC;
//        frame_start one-clock pulse at each frame boundary.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int BITS_PER_COLOUR_CHANNEL = 1,
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_FRONT     = DEF_H_FRONT,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BACK      = DEF_H_BACK,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int V_FRONT     = DEF_V_FRONT,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BACK      = DEF_V_BACK,
  parameter int SCALE_SHIFT = 2
) (
  input  logic                                 clock,
  input  logic                                 resetn,
  output logic [FB_ADDR_W-1:0]                 rd_addr,
  input  logic [3*BITS_PER_COLOUR_CHANNEL-1:0] rd_data,
  output logic [7:0]                           VGA_R,
  output logic [7:0]                           VGA_G,
  output logic [7:0]                           VGA_B,
  output logic                                 VGA_HS,
  output logic                                 VGA_VS,
  output logic                                 VGA_BLANK_N,
  output logic                                 VGA_SYNC_N,
  output logic                                 VGA_CLK,
  output logic                                 frame_start
);

  localparam int B = BITS_PER_COLOUR_CHANNEL;

  logic             phase, tick, active, hs_n, vs_n;
  logic [CNT_W-1:0] h, v;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
  ) u_tg (
    .clk_i        (clock),
    .rst_ni       (resetn),
    .phase_o      (phase),
    .tick_o       (tick),
    .h_o          (h),
    .v_o          (v),
    .active_o     (active),
    .hs_n_o       (hs_n),
    .vs_n_o       (vs_n),
    .frame_start_o(frame_start)
  );

  // Stage 1: address and delayed region flags.
  logic [FB_ADDR_W-1:0] addr_q, addr_d;
  logic                 act_q, act_d, hs1_q, hs1_d, vs1_q, vs1_d;
  // Stage 2: pin registers.
  logic [7:0]           r_q, r_d, g_q, g_d, b_q, b_d;
  logic                 blank_q, blank_d, hs2_q, hs2_d, vs2_q, vs2_d;
  logic [FB_ADDR_W-1:0] yb, xb;

  always_comb begin
    yb = FB_ADDR_W'(v >> SCALE_SHIFT);
    xb = FB_ADDR_W'(h >> SCALE_SHIFT);

    addr_d  = addr_q;
    act_d   = act_q;
    hs1_d   = hs1_q;
    vs1_d   = vs1_q;
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
    blank_d = blank_q;
    hs2_d   = hs2_q;
    vs2_d   = vs2_q;

    if (tick) begin
      // y*160 as y*128 + y*32; address holds through blanking.
      if (active) begin
        addr_d = (yb << 7) + (yb << 5) + xb;
      end
      act_d = active;
      hs1_d = hs_n;
      vs1_d = vs_n;

      // rd_data answers the address issued on the previous tick; it may be
      // X outside the active area, so the mux on act_q must gate it off.
      r_d     = act_q ? expand_channel(8'(rd_data[3*B-1 -: B]), B) : 8'h00;
      g_d     = act_q ? expand_channel(8'(rd_data[2*B-1 -: B]), B) : 8'h00;
      b_d     = act_q ? expand_channel(8'(rd_data[B-1 -: B]), B)   : 8'h00;
      blank_d = act_q;
      hs2_d   = hs1_q;
      vs2_d   = vs1_q;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_q  <= '0;
      act_q   <= 1'b0;
      hs1_q   <= 1'b1;
      vs1_q   <= 1'b1;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      blank_q <= 1'b0;
      hs2_q   <= 1'b1;
      vs2_q   <= 1'b1;
    end else begin
      addr_q  <= addr_d;
      act_q   <= act_d;
      hs1_q   <= hs1_d;
      vs1_q   <= vs1_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      blank_q <= blank_d;
      hs2_q   <= hs2_d;
      vs2_q   <= vs2_d;
    end
  end

  assign rd_addr     = addr_q;
  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;
  assign VGA_BLANK_N = blank_q;
  assign VGA_HS      = hs2_q;
  assign VGA_VS      = vs2_q;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_CLK     = phase;

endmodule

// File: tb/tb_vga_scanout.sv
// Purpose: self-checking bench for vga_scanout with a tick-indexed raster model.
// Latency: model predicts pins from the tick count since reset release.
// Backpressure: n/a; the RAM model answers one clock after rd_addr.
module tb_vga_scanout;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #10 clock = ~clock;

  // Full-size DUT.
  logic [14:0] rd_addr;
  logic [2:0]  rd_data;
  logic [7:0]  r, g, b;
  logic        hs, vs, bl, sn, vclk, fs;

  vga_scanout dut (
    .clock(clock), .resetn(resetn), .rd_addr(rd_addr), .rd_data(rd_data),
    .VGA_R(r), .VGA_G(g), .VGA_B(b), .VGA_HS(hs), .VGA_VS(vs),
    .VGA_BLANK_N(bl), .VGA_SYNC_N(sn), .VGA_CLK(vclk), .frame_start(fs)
  );

  // Shrunk-raster DUT so frame-level timing fits in a short run:
  // 24 ticks/line, 12 lines/frame -> 576 clocks/frame, VS low 96 clocks.
  logic [14:0] s_addr;
  logic [7:0]  s_r, s_g, s_b;
  logic        s_hs, s_vs, s_bl, s_sn, s_clk, s_fs;

  vga_scanout #(
    .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
    .V_ACTIVE(8),  .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) dut_s (
    .clock(clock), .resetn(resetn), .rd_addr(s_addr), .rd_data(3'b000),
    .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b), .VGA_HS(s_hs), .VGA_VS(s_vs),
    .VGA_BLANK_N(s_bl), .VGA_SYNC_N(s_sn), .VGA_CLK(s_clk), .frame_start(s_fs)
  );

  typedef struct packed {
    logic [14:0] addr;
    logic [7:0]  r, g, b;
    logic        hs, vs, bl, sn, vclk, fs;
  } pins_t;

  int    tests = 0;
  int    fails = 0;
  logic [2:0] mem [0:19199];
  pins_t q[$];

  // ---------------- reference model ----------------
  function automatic pins_t reset_pins();
    pins_t p;
    p = '0;
    p.hs = 1'b1;
    p.vs = 1'b1;
    return p;
  endfunction

  // What the pins should show for raster position n (ticks since release).
  function automatic pins_t pos_pins(input int n);
    pins_t p;
    int h, v, a;
    logic act;
    logic [2:0] col;
    h   = n % 800;
    v   = (n / 800) % 525;
    act = (h < 640) && (v < 480);
    a   = (v / 4) * 160 + h / 4;
    col = act ? mem[a] : 3'b000;
    p   = reset_pins();
    p.r  = {8{col[2]}};
    p.g  = {8{col[1]}};
    p.b  = {8{col[0]}};
    p.bl = act;
    p.hs = !(h >= 656 && h < 752);
    p.vs = !(v >= 490 && v < 492);
    return p;
  endfunction

  int    c, n, mh, mv;
  logic [14:0] m_addr;
  logic  m_act;
  pins_t cur, pend;

  // Stimulus side: RAM model plus expected-pin generator, one record per clock.
  always @(posedge clock) begin
    if (!resetn) begin
      rd_data <= 3'bxxx;
      c      = 0;
      m_addr = '0;
      m_act  = 1'b0;
      cur    = reset_pins();
      pend   = reset_pins();
      q.push_back(cur);
    end else begin
      // Data is only defined for addresses issued inside the active area.
      rd_data <= m_act ? mem[rd_addr] : 3'bxxx;
      c++;
      cur.fs = 1'b0;
      if (c % 2 == 0) begin
        n  = c / 2 - 1;
        mh = n % 800;
        mv = (n / 800) % 525;
        m_act = (mh < 640) && (mv < 480);
        if (m_act) m_addr = 15'((mv / 4) * 160 + mh / 4);
        cur    = pend;
        cur.fs = (mh == 799) && (mv == 524);
        pend   = pos_pins(n);
      end
      cur.addr = m_addr;
      cur.vclk = c[0];
      q.push_back(cur);
    end
  end

  // Monitor side: compare away from the active edge.
  pins_t exp_p, act_p;
  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_p = q.pop_front();
      act_p = {rd_addr, r, g, b, hs, vs, bl, sn, vclk, fs};
      tests++;
      if (act_p !== exp_p) begin
        fails++;
        $display("FAIL pins t=%0t got=%h want=%h", $time, act_p, exp_p);
      end
    end
  end

  // ---------------- directed measurements ----------------
  function automatic logic sig(input int sel);
    case (sel)
      0:       return bl;
      1:       return hs;
      2:       return s_vs;
      default: return s_fs;
    endcase
  endfunction

  // Count negedges until sig(sel) transitions to lvl; -1 if the budget runs out.
  task automatic wait_edge(input int sel, input logic lvl, input int budget, output int dt);
    logic prev;
    dt   = -1;
    prev = sig(sel);
    for (int i = 1; i <= budget; i++) begin
      @(negedge clock);
      if (sig(sel) == lvl && prev != lvl) begin
        dt = i;
        break;
      end
      prev = sig(sel);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic async_reset_check(input string name);
    pins_t a;
    @(negedge clock);
    #1 resetn = 1'b0;
    #1;
    a = {rd_addr, r, g, b, hs, vs, bl, sn, vclk, fs};
    tests++;
    if (a !== reset_pins()) begin
      fails++;
      $display("FAIL %s got=%h want=%h", name, a, reset_pins());
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int d;

  initial begin
    // Phase 1: random framebuffer, line and frame timing.
    for (int i = 0; i < 19200; i++) mem[i] = 3'($urandom);
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1;
    check_int("h_after_2nd_edge", int'(dut.u_tg.h_q), 1);
    wait_edge(0, 1'b1, 100, d);   check_int("blank_first_rise", d, 3);
    wait_edge(1, 1'b0, 2000, d);  check_int("hs_fall_after_blank", d, 1312);
    wait_edge(1, 1'b1, 400, d);   check_int("hs_low", d, 192);
    wait_edge(1, 1'b0, 2000, d);  check_int("hs_high", d, 1408);
    wait_edge(3, 1'b1, 1200, d);
    wait_edge(3, 1'b0, 4, d);     check_int("fs_width", d, 1);
    wait_edge(3, 1'b1, 1200, d);  check_int("fs_period", d + 1, 576);
    wait_edge(2, 1'b0, 1200, d);
    wait_edge(2, 1'b1, 400, d);   check_int("vs_low", d, 96);
    repeat (15000 + $urandom_range(0, 4000)) @(negedge clock);
    async_reset_check("reset_mid_frame_1");

    // Phase 2: constant colour 3'b101.
    for (int i = 0; i < 19200; i++) mem[i] = 3'b101;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    repeat (3000 + $urandom_range(0, 1500)) @(negedge clock);
    async_reset_check("reset_mid_frame_2");

    // Phase 3: colour = low address bits, exposes pipeline misalignment.
    for (int i = 0; i < 19200; i++) mem[i] = 3'(i);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    repeat (4000) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_scanout.md
# vga_scanout

Frame-buffer reader and VGA timing generator for the 160x120 display path. The pixel writers (object drawing FSMs) store colour through the adapter's x/y/plot port. This block is the other end of that buffer. It continuously scans a synchronous video RAM, upsamples each stored pixel 4x4 to 640x480@60 Hz, and drives the DAC and sync pins. It also emits a per-frame pulse that animation logic can use in place of a free-running slow counter.

## Interface
Parameters:
- BITS_PER_COLOUR_CHANNEL, 1: bits per R/G/B channel stored in RAM.
- H_ACTIVE / H_FRONT / H_SYNC / H_BACK, 640 / 16 / 96 / 48: horizontal timing, in pixel ticks.
- V_ACTIVE / V_FRONT / V_SYNC / V_BACK, 480 / 10 / 2 / 33: vertical timing, in lines.
- SCALE_SHIFT, 2: log2 of the upsample factor. 160 = 640>>2.

Ports:
- clock, in, 1: 50 MHz system clock.
- resetn, in, 1: asynchronous, active-low reset.
- rd_addr, out, 15: video RAM read address, y*160 + x.
- rd_data, in, 3*BITS_PER_COLOUR_CHANNEL: RAM read data, valid one clock after rd_addr.
- VGA_R / VGA_G / VGA_B, out, 8 each: DAC colour.
- VGA_HS / VGA_VS, out, 1 each: syncs, active low.
- VGA_BLANK_N, out, 1: high during the active area.
- VGA_SYNC_N, out, 1: constant 0.
- VGA_CLK, out, 1: 25 MHz pixel clock.
- frame_start, out, 1: one-clock pulse at the start of each frame.

## Operation
- A phase register toggles on every clock. A pixel tick occurs on the clock where phase == 1, giving one tick per 2 clocks.
- Counters are updated only on ticks:
  - h counts 0..799 and wraps to 0.
  - On h wrap, v counts 0..524 and wraps to 0.
- Region decode, evaluated on the current (h,v):
  - active = h < 640 && v < 480.
  - hs_n = 0 iff 656 <= h < 752.
  - vs_n = 0 iff 490 <= v < 492.
- Pipeline stage 1, on tick k:
  - Register rd_addr = ((v>>2)<<7) + ((v>>2)<<5) + (h>>2). This is 15-bit unsigned, no overflow; the max is 19199.
  - When inactive, rd_addr holds its last value. It is not forced to 0.
  - Also register active_d, hs_d and vs_d for the same (h,v).
  - Advance the counters.
- Pipeline stage 2, on tick k+1:
  - VGA_R/G/B are the channel bits of rd_data, replicated MSB-first to fill 8 bits (1-bit 1 -> 8'hFF). They are forced to 0 when active_d = 0.
  - VGA_BLANK_N = active_d, VGA_HS = hs_d, VGA_VS = vs_d.
  - rd_data is ignored (may be X) when active_d = 0.
- Channel order in rd_data is {R,G,B}, with R in the MSBs.
- frame_start is high for exactly the one clock following the tick on which the counters wrap from (799,524) to (0,0).

## Timing
- Reset values, asserted asynchronously:
  - phase = 0, h = 0, v = 0, rd_addr = 0.
  - RGB = 0, VGA_BLANK_N = 0, VGA_HS = 1, VGA_VS = 1.
  - VGA_CLK = 0, frame_start = 0.
- Reset asserted mid-frame: every output takes its reset value immediately. The first tick after release occurs on the second rising clock edge.
- Clock and tick relationships:
  - VGA_CLK = phase, so DAC outputs change on the clock after VGA_CLK's falling edge and are stable at its rising edge.
  - RAM sees rd_addr one clock after the tick and returns data one clock later. That is exactly the next tick, so there are no wait states.
  - Latency from counter value to pins is 2 ticks (4 clocks). Sync, blank and colour stay mutually aligned.
- Periods:
  - Line: 800 ticks = 1600 clocks.
  - Frame: 525 lines = 840000 clocks.
  - HS low: 96 ticks.
  - VS low: 2 lines = 1600 ticks.
- Each framebuffer pixel spans 4 consecutive ticks and 4 consecutive lines.

## Structure
- Package vga_pkg holds:
  - the timing constants, FB_WIDTH = 160, FB_HEIGHT = 120, FB_ADDR_W = 15;
  - the colour-expansion rule as a shared function.
- Sub-module vga_timing_gen holds phase, the h/v counters, region decode and frame_start.
- vga_scanout holds the address arithmetic, the pipeline registers and colour expansion.

## Test plan
- **Reset:** assert resetn low at an arbitrary h/v mid-frame.
  - Outputs take their reset values within the same clock, without waiting for an edge.
  - After release, h = 1 after the 2nd edge.
- **Line timing:** measure VGA_HS.
  - Low for 192 clocks, period 1600 clocks.
  - Falling edge 1312 clocks after the VGA_BLANK_N rise.
- **Frame timing:** measure VGA_VS and frame_start.
  - VGA_VS is low for 3200 clocks.
  - frame_start pulses every 840000 clocks, for one clock each time.
- **Address:** check rd_addr at chosen (h,v).
  - 0 for h = 0..3, v = 0; 1 at h = 4.
  - 160 at v = 4, h = 0.
  - 19199 at (639,479).
  - Unchanged across the h = 640..799 blanking.
- **Colour:** a RAM model (1-clock latency) returns 3'b101.
  - Active area: R = FF, G = 00, B = FF.
  - With rd_data = X during blanking: RGB = 0 and no X reaches the pins.
- **Alignment:** a RAM model returns rd_data = addr[2:0].
  - The first four active pixels of line 0 show colour 0; the next four show colour 1.
  - This confirms the 2-tick pipeline alignment against VGA_BLANK_N.
